cory_s2p: RTL and testbench
===========================

# cory_s2p

Narrow-to-wide serial-to-parallel packer; direct downstream stage of the `cory` wide-to-narrow splitter. It accepts R consecutive N-bit slices on a valid/ready stream, each tagged with its slice index. It assembles them into one A-bit word and emits that word on a registered valid/ready output. With the output register accepting, it sustains one narrow beat per cycle with no bubbles.

## Interface
- N, 8, bits per slice
- R, 2, slices per word; legal values 2, 4, 8, 16
- A, N*R, output word width
- BS, ceil(log2(R)) (1/2/3/4 for R=2/4/8/16), slice-index width
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_a_v  in  1  input slice valid
- i_a_d  in  N  input slice data
- i_a_s  in  BS  input slice index (0 = first, least-significant slice)
- o_a_r  out  1  input ready
- o_z_v  out  1  output word valid (registered)
- o_z_d  out  A  output word (registered)
- i_z_r  in  1  output ready
- o_err  out  1  slice-sequence error pulse (registered)

One clock (clk); reset is asynchronous and active-low (reset_n).

## Operation
- Handshake on both ports: transfer when v & r; valid must not depend on ready; data held stable while v & !r.
- State:
  - cnt[BS-1:0], the expected slice index.
  - acc[(R-1)*N-1:0], holding partial slices.
  - Output register z_v/z_d.
- Accepted slice k = cnt is placed at bits [k*N +: N]; slice 0 is LSBs.
- Non-last slice (cnt < R-1): write into acc; cnt <= cnt+1.
- Last slice (cnt == R-1): z_d <= {i_a_d, acc}; z_v <= 1; cnt <= 0.
- o_a_r = (cnt != R-1) | !z_v | i_z_r. Only the last slice can stall. Ready is combinational from i_z_r; there is no combinational path from i_a_v to o_a_r.
- Output: z_v clears on (z_v & i_z_r) unless a new word loads in the same cycle. Load and unload in the same cycle keeps z_v=1 with the new data.
- acc is not cleared between words; bits not yet written are don't-care and never reach o_z_d.

## Timing
- Reset values: cnt=0, acc=0, o_z_v=0, o_z_d=0, o_err=0. o_a_r=1 while in reset and the cycle after.
- Latency: last slice accepted on edge t → o_z_v=1 after edge t (visible cycle t+1).
- Throughput: R input cycles per output word at full rate, given i_z_r=1 on the output cycle.
- Output held (i_z_r=0) while the next word's slices 0..R-2 arrive: the slices are accepted. o_a_r drops at cnt=R-1 until the output is consumed.
- Wrap-around: cnt goes R-1 → 0 on the last-slice transfer only.
- Reset mid-word: partial word discarded; the next accepted slice is treated as slice 0.
- o_err pulses exactly one cycle, the cycle after the offending transfer.

## Configuration
- CORY_S2P_SCHK_EN defined: on each accepted slice, i_a_s is compared with cnt. On mismatch:
  - o_err <= 1 for one cycle.
  - If i_a_s == 0, the beat is taken as slice 0 of a new word: it is written at bits [0 +: N] and cnt <= 1. The prior partial word is dropped.
  - Otherwise the beat is dropped and cnt <= 0.
  - No output word is produced from a mismatched beat.
  - o_a_r is unaffected.
- Not defined: i_a_s is ignored, o_err is tied 0, and packing follows cnt only.
- Under SIM, R not in {2,4,8,16} prints ERROR and calls $finish.

## Test plan
- N=8, R=4, i_z_r=1; slices 0x11,0x22,0x33,0x44 with s=0..3 on back-to-back cycles → o_z_d=0x44332211, o_z_v=1 for exactly one cycle, the cycle after 0x44; o_a_r stays 1.
- R=4, continuous input of 3 words, i_z_r=1 → 3 words out every 4 cycles, no bubbles, correct order.
- R=4, i_z_r=0 after the first word → next slices 0..2 accepted, o_a_r=0 at cnt=3, o_z_d held. Raising i_z_r → first word consumed and second loaded the same cycle, o_z_v stays 1.
- Assert reset_n=0 after 2 of 4 slices, release, send 0xA0..0xA3 → o_z_d=0xA3A2A1A0, no error.
- CORY_S2P_SCHK_EN, R=4: send s=0,1,0,1,2,3 with data 1..6 → o_err pulses once, after the third beat; word out = 0x06050403.
- CORY_S2P_SCHK_EN, R=4: send s=0,2 then s=0..3 with 0xB0..0xB3 → o_err pulse after s=2 (beat dropped), then o_z_d=0xB3B2B1B0.

Source files
------------

// File: rtl/cory_s2p.sv
// rtl/cory_s2p.sv - narrow-to-wide slice packer with registered valid/ready output
// Optional slice-index checking is built in with `define CORY_S2P_SCHK_EN.
module cory_s2p #(
  parameter  int N  = 8,
  parameter  int R  = 2,
  localparam int A  = N * R,
  localparam int BS = (R <= 2) ? 1 : $clog2(R)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_v,
  input  logic [N-1:0]  i_a_d,
  input  logic [BS-1:0] i_a_s,
  output logic          o_a_r,
  output logic          o_z_v,
  output logic [A-1:0]  o_z_d,
  input  logic          i_z_r,
  output logic          o_err
);

  localparam logic [BS-1:0] LAST = BS'(R - 1);

  logic [BS-1:0]        cnt, cnt_nxt;
  logic [(R-1)*N-1:0]   acc, acc_nxt;
  logic                 z_v, z_v_nxt;
  logic [A-1:0]         z_d, z_d_nxt;
  logic                 err, err_nxt;
  logic                 xfer;
  logic                 seq_ok;
  logic                 restart;

`ifdef SIM
  initial begin
    if (!(R == 2 || R == 4 || R == 8 || R == 16)) begin
      $display("ERROR: cory_s2p R=%0d not in {2,4,8,16}", R);
      $finish;
    end
  end
`endif

`ifdef CORY_S2P_SCHK_EN
  assign seq_ok  = (i_a_s == cnt);
  assign restart = (i_a_s == '0);
`else
  logic unused_s;
  assign unused_s = ^i_a_s;
  assign seq_ok   = 1'b1;
  assign restart  = 1'b0;
`endif

  assign xfer = i_a_v & o_a_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      acc <= '0;
      z_v <= 1'b0;
      z_d <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
      z_v <= z_v_nxt;
      z_d <= z_d_nxt;
      err <= err_nxt;
    end
  end

  // An out-of-order index 0 restarts the word; any other mismatch drops the beat.
  always_comb begin
    cnt_nxt = cnt;
    acc_nxt = acc;
    z_v_nxt = z_v;
    z_d_nxt = z_d;
    err_nxt = 1'b0;
    if (z_v && i_z_r) begin
      z_v_nxt = 1'b0;
    end
    if (xfer) begin
      if (!seq_ok) begin
        err_nxt = 1'b1;
        if (restart) begin
          acc_nxt[0 +: N] = i_a_d;
          cnt_nxt         = BS'(1);
        end else begin
          cnt_nxt = '0;
        end
      end else if (cnt == LAST) begin
        z_d_nxt = {i_a_d, acc};
        z_v_nxt = 1'b1;
        cnt_nxt = '0;
      end else begin
        for (int k = 0; k < R - 1; k++) begin
          if (cnt == BS'(k)) begin
            acc_nxt[k*N +: N] = i_a_d;
          end
        end
        cnt_nxt = cnt + BS'(1);
      end
    end
  end

  // Only the last slice can stall, and only while an unconsumed word is held.
  always_comb begin
    o_a_r = (cnt != LAST) | ~z_v | i_z_r;
    o_z_v = z_v;
    o_z_d = z_d;
    o_err = err;
  end

endmodule

// File: tb/tb_cory_s2p.sv
// tb/tb_cory_s2p.sv - self-checking bench for cory_s2p (N=8, R=4)
module tb_cory_s2p;

  localparam int N = 8;
  localparam int R = 4;
  localparam int A = N * R;
`ifdef CORY_S2P_SCHK_EN
  localparam bit SCHK = 1'b1;
`else
  localparam bit SCHK = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic [1:0]   i_a_s;
  logic         o_a_r;
  logic         o_z_v;
  logic [A-1:0] o_z_d;
  logic         i_z_r;
  logic         o_err;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] part[$];
  logic         mzv;
  logic [A-1:0] mzd;
  logic         merr;

  cory_s2p #(.N(N), .R(R)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i_a_v  (i_a_v),
    .i_a_d  (i_a_d),
    .i_a_s  (i_a_s),
    .o_a_r  (o_a_r),
    .o_z_v  (o_z_v),
    .o_z_d  (o_z_d),
    .i_z_r  (i_z_r),
    .o_err  (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A-1:0] pack_word();
    logic [A-1:0] w = '0;
    foreach (part[k]) w = w | (A'(part[k]) << (N * k));
    return w;
  endfunction

  task automatic cycle(input logic v, input logic [N-1:0] d, input logic [1:0] s,
                       input logic zr, output bit took);
    bit rdy;
    i_a_v = v;
    i_a_d = d;
    i_a_s = s;
    i_z_r = zr;
    #1;
    rdy = !(part.size() == R - 1 && mzv && !zr);
    chk("o_a_r", o_a_r, rdy);
    took = v && rdy;
    @(posedge clk);
    #1;
    merr = 1'b0;
    if (mzv && zr) mzv = 1'b0;
    if (took) begin
      if (SCHK && int'(s) != part.size()) begin
        merr = 1'b1;
        part.delete();
        if (s == 2'd0) part.push_back(d);
      end else begin
        part.push_back(d);
        if (part.size() == R) begin
          mzd = pack_word();
          mzv = 1'b1;
          part.delete();
        end
      end
    end
    chk("o_z_v", o_z_v, mzv);
    chk("o_z_d", o_z_d, mzd);
    chk("o_err", o_err, merr);
  endtask

  task automatic do_reset();
    i_a_v   = 1'b0;
    i_z_r   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_z_v", o_z_v, 1'b0);
    chk("rst_z_d", o_z_d, '0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_a_r", o_a_r, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    part.delete();
    mzv  = 1'b0;
    mzd  = '0;
    merr = 1'b0;
    #1;
    chk("post_rst_a_r", o_a_r, 1'b1);
  endtask

  initial begin
    bit           took;
    bit           pv;
    logic [N-1:0] pd;
    logic [1:0]   ps;
    logic         zr;

    reset_n = 1'b0;
    i_a_v   = 1'b0;
    i_a_d   = '0;
    i_a_s   = '0;
    i_z_r   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back word, output always ready
    for (int k = 0; k < R; k++) cycle(1'b1, N'(8'h11 * (k + 1)), 2'(k), 1'b1, took);
    chk("word_44332211", o_z_d, 32'h44332211);
    cycle(1'b0, '0, '0, 1'b1, took);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Three continuous random words
    for (int k = 0; k < 3 * R; k++) cycle(1'b1, N'($urandom), 2'(k % R), 1'b1, took);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Output held while next word's slices arrive; last slice stalls
    for (int k = 0; k < R; k++) cycle(1'b1, N'($urandom), 2'(k), 1'b1, took);
    pd = N'($urandom);
    for (int k = 0; k < R - 1; k++) cycle(1'b1, N'($urandom), 2'(k), 1'b0, took);
    for (int k = 0; k < 3; k++) cycle(1'b1, pd, 2'(R - 1), 1'b0, took);
    cycle(1'b1, pd, 2'(R - 1), 1'b1, took);
    chk("held_load_took", took, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Reset mid-word discards the partial word
    cycle(1'b1, 8'h55, 2'd0, 1'b1, took);
    cycle(1'b1, 8'h66, 2'd1, 1'b1, took);
    do_reset();
    for (int k = 0; k < R; k++) cycle(1'b1, N'(8'hA0 + k), 2'(k), 1'b1, took);
    chk("word_A3A2A1A0", o_z_d, 32'hA3A2A1A0);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Index restart at 0 mid-word
    do_reset();
    begin
      logic [1:0] sseq[6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
      for (int k = 0; k < 6; k++) cycle(1'b1, N'(k + 1), sseq[k], 1'b1, took);
    end
    if (SCHK) chk("word_06050403", o_z_d, 32'h06050403);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Skipped index drops the beat
    do_reset();
    cycle(1'b1, 8'hC0, 2'd0, 1'b1, took);
    cycle(1'b1, 8'hC1, 2'd2, 1'b1, took);
    for (int k = 0; k < R; k++) cycle(1'b1, N'(8'hB0 + k), 2'(k), 1'b1, took);
    if (SCHK) chk("word_B3B2B1B0", o_z_d, 32'hB3B2B1B0);
    cycle(1'b0, '0, '0, 1'b1, took);

    // Random traffic with occasional bad indices and output backpressure
    pv = 1'b0;
    pd = '0;
    ps = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 9) < 7);
        pd = N'($urandom);
        ps = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'(part.size());
      end
      zr = ($urandom_range(0, 3) != 0);
      cycle(pv, pv ? pd : '0, ps, zr, took);
      if (took) pv = 1'b0;
    end
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1, took);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
